// File: rtl/m6809_pkg.sv
// m6809_pkg: shared types and constants for the 6809 SOC control logic
package m6809_pkg;

   typedef enum logic [1:0] {
      ST_RESET_HOLD = 2'd0,
      ST_RUN        = 2'd1,
      ST_HALT_WAIT  = 2'd2,
      ST_HALTED     = 2'd3
   } state_t;

   // {BA,BS} pattern the core drives once it has halted and released the bus
   localparam logic [1:0] BUS_STATE_HALT_GRANT = 2'b11;

   localparam int POR_CYCLES_DEF = 5;

endpackage

// File: rtl/m6809_reset_halt_ctrl.sv
// m6809_reset_halt_ctrl: drives the 6809 RESET/HALT inputs with reset stretch,
// BA/BS-confirmed halt handshake and a watchdog on unacknowledged halts
module m6809_reset_halt_ctrl
   import m6809_pkg::*;
#(
   parameter int POR_CYCLES   = POR_CYCLES_DEF,
   parameter int HALT_TIMEOUT = 255,
   parameter int CNT_W        = 8
) (
   input  logic       i_clk,
   input  logic       i_reset_b,
   input  logic       i_sw_reset_req,
   input  logic       i_halt_req,
   input  logic       i_cpu_ba,
   input  logic       i_cpu_bs,
   output logic       o_cpu_reset_b,
   output logic       o_cpu_halt_b,
   output logic       o_halt_ack,
   output logic       o_halt_timeout,
   output logic [1:0] o_state
);

   localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] WDG_LAST = CNT_W'(HALT_TIMEOUT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cpu_reset_b;
   logic             r_cpu_halt_b;
   logic             r_halt_ack;
   logic             r_halt_timeout;
   logic             w_granted;

   assign w_granted      = {i_cpu_ba, i_cpu_bs} == BUS_STATE_HALT_GRANT;
   assign o_cpu_reset_b  = r_cpu_reset_b;
   assign o_cpu_halt_b   = r_cpu_halt_b;
   assign o_halt_ack     = r_halt_ack;
   assign o_halt_timeout = r_halt_timeout;
   assign o_state        = r_state;

   always_ff @(posedge i_clk) begin
      if (!i_reset_b) begin
         r_state        <= ST_RESET_HOLD;
         r_cnt          <= '0;
         r_cpu_reset_b  <= 1'b0;
         r_cpu_halt_b   <= 1'b1;
         r_halt_ack     <= 1'b0;
         r_halt_timeout <= 1'b0;
      end else if (i_sw_reset_req) begin
         r_state       <= ST_RESET_HOLD;
         r_cnt         <= '0;
         r_cpu_reset_b <= 1'b0;
         r_cpu_halt_b  <= 1'b1;
         r_halt_ack    <= 1'b0;
      end else begin
         case (r_state)
            ST_RESET_HOLD: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == POR_LAST) begin
                  r_state       <= ST_RUN;
                  r_cpu_reset_b <= 1'b1;
               end
            end
            ST_RUN: begin
               if (i_halt_req) begin
                  r_state      <= ST_HALT_WAIT;
                  r_cpu_halt_b <= 1'b0;
                  r_cnt        <= '0;
               end
            end
            ST_HALT_WAIT: begin
               // acknowledge wins over abandon, abandon wins over the watchdog
               if (w_granted) begin
                  r_state    <= ST_HALTED;
                  r_halt_ack <= 1'b1;
               end else if (!i_halt_req) begin
                  r_state      <= ST_RUN;
                  r_cpu_halt_b <= 1'b1;
               end else if (r_cnt == WDG_LAST) begin
                  r_state        <= ST_RESET_HOLD;
                  r_cnt          <= '0;
                  r_halt_timeout <= 1'b1;
                  r_cpu_reset_b  <= 1'b0;
                  r_cpu_halt_b   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_HALTED: begin
               if (!i_halt_req) begin
                  r_state      <= ST_RUN;
                  r_cpu_halt_b <= 1'b1;
                  r_halt_ack   <= 1'b0;
               end else if (!w_granted) begin
                  r_state    <= ST_HALT_WAIT;
                  r_halt_ack <= 1'b0;
                  r_cnt      <= '0;
               end
            end
            default: r_state <= ST_RESET_HOLD;
         endcase
      end
   end

endmodule
